// File: rtl/vector_rf_context_engine_pkg.sv
// -----------------------------------------------------------------------------
// vector_rf_context_engine_pkg
// Shared types for the vector register file context save/restore engine.
//   word_t      : one 32-bit lane data word
//   regbits_t   : architectural register index (32 registers)
//   ctx_op_t    : requested operation (save to stream / restore from stream)
//   ctx_state_t : sequencer state
//   lane_w()    : index width for a given lane count (never below 1 bit)
// -----------------------------------------------------------------------------
package vector_rf_context_engine_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic {
        CTX_SAVE    = 1'b0,
        CTX_RESTORE = 1'b1
    } ctx_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2,
        DONE    = 2'd3
    } ctx_state_t;

    function automatic int lane_w(input int threads);
        return (threads > 1) ? $clog2(threads) : 1;
    endfunction

endpackage

// File: rtl/vector_rf_context_engine_if.sv
// -----------------------------------------------------------------------------
// vector_rf_context_engine_if
// Write/read-select side of the vector register file.
//   wen    : per-lane write enable
//   wsel   : write register index
//   rsel1  : read port 1 register index
//   rsel2  : read port 2 register index
//   wdata  : per-lane write data
//   rdata1 : per-lane read data for rsel1 (combinational in the register file)
// Modports:
//   master : the side that drives selects/writes (context engine)
//   slave  : the register file itself
// -----------------------------------------------------------------------------
interface vector_rf_context_engine_if #(
    parameter int THREADS = 4
) ();
    import vector_rf_context_engine_pkg::*;

    logic [THREADS-1:0]  wen;
    regbits_t            wsel;
    regbits_t            rsel1;
    regbits_t            rsel2;
    word_t [THREADS-1:0] wdata;
    word_t [THREADS-1:0] rdata1;

    modport master (
        output wen, wsel, rsel1, rsel2, wdata,
        input  rdata1
    );

    modport slave (
        input  wen, wsel, rsel1, rsel2, wdata,
        output rdata1
    );

endinterface

// File: rtl/vector_rf_context_engine_lane_next_sel.sv
// -----------------------------------------------------------------------------
// vector_rf_context_engine_lane_next_sel
// Combinational priority finder over the lane mask.
//   mask       : participating lanes
//   cur_lane   : lane currently being transferred
//   next_lane  : lowest set mask bit strictly above cur_lane (first_lane on wrap)
//   wrap       : no set bit above cur_lane; the register index must advance
//   first_lane : lowest set mask bit (0 when the mask is empty)
// -----------------------------------------------------------------------------
module vector_rf_context_engine_lane_next_sel #(
    parameter int THREADS = 4,
    parameter int LANE_W  = 2
) (
    input  logic [THREADS-1:0] mask,
    input  logic [LANE_W-1:0]  cur_lane,
    output logic [LANE_W-1:0]  next_lane,
    output logic               wrap,
    output logic [LANE_W-1:0]  first_lane
);

    // Scanning downward lets the last hit be the lowest qualifying bit.
    always_comb begin
        first_lane = '0;
        next_lane  = '0;
        wrap       = 1'b1;
        for (int i = THREADS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_lane = LANE_W'(i);
            end
            if (mask[i] && (i > int'(cur_lane))) begin
                next_lane = LANE_W'(i);
                wrap      = 1'b0;
            end
        end
        if (wrap) begin
            next_lane = first_lane;
        end
    end

endmodule

// File: rtl/vector_rf_context_engine.sv
// -----------------------------------------------------------------------------
// vector_rf_context_engine
// Saves the vector register file to an outbound word stream or restores it
// from an inbound word stream, one register of one lane per handshake.
// Order is register-major, lane-minor, ascending, registers 1..REGS-1 only,
// unmasked lanes skipped.
//   CLK, nRST              : clock, synchronous active-low reset
//   cmd_valid/cmd_ready    : command handshake (ready only when idle)
//   cmd_op, cmd_mask       : operation and participating lanes (latched on accept)
//   busy                   : engine owns the register file port
//   done                   : one-cycle completion pulse
//   rf                     : register file select/write port (master side)
//   out_valid/ready/data   : save stream
//   in_valid/ready/data    : restore stream
// -----------------------------------------------------------------------------
module vector_rf_context_engine
    import vector_rf_context_engine_pkg::*;
#(
    parameter int THREADS = 4,
    parameter int REGS    = 32
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  ctx_op_t                     cmd_op,
    input  logic [THREADS-1:0]          cmd_mask,
    output logic                        busy,
    output logic                        done,
    vector_rf_context_engine_if.master  rf,
    output logic                        out_valid,
    input  logic                        out_ready,
    output word_t                       out_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  word_t                       in_data
);

    localparam int       LANE_W   = lane_w(THREADS);
    localparam regbits_t LAST_REG = regbits_t'(REGS - 1);

    ctx_state_t         state;
    ctx_state_t         next_state;
    logic [THREADS-1:0] mask_q;
    logic [THREADS-1:0] sel_mask;
    regbits_t           cur_reg;
    logic [LANE_W-1:0]  cur_lane;
    logic [LANE_W-1:0]  next_lane;
    logic [LANE_W-1:0]  first_lane;
    logic               wrap;
    logic               hs;

    // While idle the finder looks at the incoming mask so the accept edge can
    // load the first lane directly; afterwards it tracks the latched mask.
    assign sel_mask = (state == IDLE) ? cmd_mask : mask_q;

    vector_rf_context_engine_lane_next_sel #(
        .THREADS (THREADS),
        .LANE_W  (LANE_W)
    ) u_lane_next_sel (
        .mask       (sel_mask),
        .cur_lane   (cur_lane),
        .next_lane  (next_lane),
        .wrap       (wrap),
        .first_lane (first_lane)
    );

    assign hs = ((state == SAVE) && out_ready) || ((state == RESTORE) && in_valid);

    // ---- state register ----
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---- register / lane cursor ----
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cur_reg  <= '0;
            cur_lane <= '0;
            mask_q   <= '0;
        end else if ((state == IDLE) && cmd_valid) begin
            mask_q   <= cmd_mask;
            cur_reg  <= regbits_t'(1);
            cur_lane <= first_lane;
        end else if (hs) begin
            if (wrap) begin
                cur_reg  <= cur_reg + regbits_t'(1);
                cur_lane <= first_lane;
            end else begin
                cur_lane <= next_lane;
            end
        end
    end

    // ---- next-state logic ----
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_mask == '0) begin
                        next_state = DONE;
                    end else if (cmd_op == CTX_SAVE) begin
                        next_state = SAVE;
                    end else begin
                        next_state = RESTORE;
                    end
                end
            end
            SAVE, RESTORE: begin
                // wrap marks the highest set lane of the current register
                if (hs && wrap && (cur_reg == LAST_REG)) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---- outputs and stream / register-file muxing ----
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == DONE);
        out_valid = 1'b0;
        out_data  = '0;
        in_ready  = 1'b0;
        rf.wen    = '0;
        rf.wsel   = '0;
        rf.rsel1  = '0;
        rf.rsel2  = '0;
        rf.wdata  = '0;
        case (state)
            SAVE: begin
                // cursor only moves on a handshake, so rsel1/out_data hold under stall
                rf.rsel1  = cur_reg;
                out_valid = 1'b1;
                out_data  = rf.rdata1[cur_lane];
            end
            RESTORE: begin
                in_ready = 1'b1;
                rf.wsel  = cur_reg;
                for (int i = 0; i < THREADS; i++) begin
                    rf.wdata[i] = in_data;
                end
                rf.wen[cur_lane] = in_valid;
            end
            default: begin
            end
        endcase
    end

endmodule
